// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the nn_frame_adapter slice.
//  - Default word width and frame sizes used by the adapter and its serializer.
//  - word_t: one signed fixed-point sample/result word at the default width.
//  - adapter_state_t: the adapter's frame-level state machine encoding.
//  - idx_width(): index width for a given element count, never less than 1 bit.
package nn_pkg;

    localparam int DEFAULT_WIDTH       = 32'sd16;
    localparam int DEFAULT_INPUT_SIZE  = 32'sd16;
    localparam int DEFAULT_OUTPUT_SIZE = 32'sd5;
    localparam int DEFAULT_TIMEOUT     = 32'sd4096;

    typedef logic signed [DEFAULT_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FIRE  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } adapter_state_t;

    // A single-element array or counter still needs one index bit.
    function automatic int idx_width(input int size);
        return (size > 32'sd1) ? $clog2(size) : 32'sd1;
    endfunction

endpackage

// File: rtl/nn_result_serializer.sv
// nn_result_serializer: holds one captured result frame and replays it as a
// valid/ready word stream.
//  clk, reset      clock and asynchronous active-low reset
//  capture         one-cycle strobe: load capture_data and start streaming
//  capture_data    OUTPUT_SIZE packed words, element 0 in the low bits
//  m_valid/m_ready output stream handshake
//  m_data, m_last  current word and end-of-frame marker (registered)
//  done            high in the cycle of the final word's handshake
module nn_result_serializer
    import nn_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int OUTPUT_SIZE = DEFAULT_OUTPUT_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         capture,
    input  logic [WIDTH*OUTPUT_SIZE-1:0] capture_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_data,
    output logic                         m_last,
    output logic                         done
);

    localparam int RW = idx_width(OUTPUT_SIZE);
    localparam logic [RW-1:0] LAST_IDX = RW'(OUTPUT_SIZE - 32'sd1);

    logic [WIDTH-1:0] result_q [OUTPUT_SIZE];
    logic [WIDTH-1:0] result_d [OUTPUT_SIZE];
    logic [RW-1:0]    rd_idx_q, rd_idx_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_last_q, m_last_d;

    logic          hs_s;
    logic          last_hs_s;
    logic [RW-1:0] rd_next_s;

    // Handshake decode kept outside the update block so done has no path back
    // through the capture strobe.
    assign hs_s      = m_valid_q && m_ready;
    assign last_hs_s = hs_s && (rd_idx_q == LAST_IDX);
    assign rd_next_s = rd_idx_q + RW'(1'b1);

    // Next-state for result store, read index and the registered output word.
    always_comb begin
        result_d  = result_q;
        rd_idx_d  = rd_idx_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (capture) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                result_d[i] = capture_data[i*WIDTH +: WIDTH];
            end
            rd_idx_d  = '0;
            m_valid_d = 1'b1;
            // Present word 0 straight from the bus; result_q is loaded at the same edge.
            m_data_d  = capture_data[WIDTH-1:0];
            m_last_d  = (LAST_IDX == {RW{1'b0}});
        end else if (last_hs_s) begin
            rd_idx_d  = '0;
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_last_d  = 1'b0;
        end else if (hs_s) begin
            // rd_next_s never exceeds LAST_IDX in this branch.
            rd_idx_d = rd_next_s;
            m_data_d = result_q[rd_next_s];
            m_last_d = (rd_next_s == LAST_IDX);
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Result store and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                result_q[i] <= '0;
            end
            rd_idx_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            result_q  <= result_d;
            rd_idx_q  <= rd_idx_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign done    = last_hs_s;

endmodule

// File: rtl/nn_frame_adapter.sv
// nn_frame_adapter: stream-side front end for the inference core.
// Collects INPUT_SIZE words into a frame, pulses the core, waits for its
// result (with a timeout) and streams the OUTPUT_SIZE results back out.
//  clk, reset                     clock and asynchronous active-low reset
//  s_valid/s_ready/s_data         input word stream
//  core_input_ready               one-cycle launch pulse to the core
//  core_input_data                frame, element 0 (first word) in the low bits
//  core_output_ready/_data        core result strobe/level and result words
//  m_valid/m_ready/m_data/m_last  result word stream, m_last on the final word
//  err_timeout                    sticky flag: the core failed to answer in time
module nn_frame_adapter
    import nn_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int INPUT_SIZE  = DEFAULT_INPUT_SIZE,
    parameter int OUTPUT_SIZE = DEFAULT_OUTPUT_SIZE,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_data,
    output logic                         core_input_ready,
    output logic [WIDTH*INPUT_SIZE-1:0]  core_input_data,
    input  logic                         core_output_ready,
    input  logic [WIDTH*OUTPUT_SIZE-1:0] core_output_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_data,
    output logic                         m_last,
    output logic                         err_timeout
);

    localparam int WW = idx_width(INPUT_SIZE);
    localparam int CW = idx_width(TIMEOUT);
    localparam logic [WW-1:0] LAST_WR  = WW'(INPUT_SIZE - 32'sd1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 32'sd1);

    adapter_state_t   state_q, state_d;
    logic [WIDTH-1:0] frame_q [INPUT_SIZE];
    logic [WIDTH-1:0] frame_d [INPUT_SIZE];
    logic [WW-1:0]    wr_idx_q, wr_idx_d;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             s_ready_q, s_ready_d;
    logic             core_input_ready_q, core_input_ready_d;
    logic             err_timeout_q, err_timeout_d;

    logic fill_hs_s;
    logic capture_s;
    logic drain_done_s;

    // s_ready_q is only ever high in FILL, so it alone qualifies an input beat.
    assign fill_hs_s = (state_q == FILL) && s_valid && s_ready_q;
    // Only WAIT may capture: a level left over from the previous frame is
    // still visible during FIRE and must not be taken as this frame's result.
    assign capture_s = (state_q == WAIT) && core_output_ready;

    // Frame-level FSM, frame store, write index and timeout counter.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        wr_idx_d      = wr_idx_q;
        wait_cnt_d    = wait_cnt_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            FILL: begin
                if (fill_hs_s) begin
                    frame_d[wr_idx_q] = s_data;
                    if (wr_idx_q == LAST_WR) begin
                        wr_idx_d = '0;
                        state_d  = FIRE;
                    end else begin
                        wr_idx_d = wr_idx_q + WW'(1'b1);
                    end
                end else begin
                    state_d = FILL;
                end
            end
            FIRE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (capture_s) begin
                    state_d = DRAIN;
                end else if (wait_cnt_q == LAST_CNT) begin
                    err_timeout_d = 1'b1;
                    state_d       = FILL;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1'b1);
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_d = FILL;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        // Handshake outputs are registered copies of the next state.
        s_ready_d          = (state_d == FILL);
        core_input_ready_d = (state_d == FIRE);
    end

    // State, frame store and control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                frame_q[i] <= '0;
            end
            wr_idx_q           <= '0;
            wait_cnt_q         <= '0;
            s_ready_q          <= 1'b0;
            core_input_ready_q <= 1'b0;
            err_timeout_q      <= 1'b0;
        end else begin
            state_q            <= state_d;
            frame_q            <= frame_d;
            wr_idx_q           <= wr_idx_d;
            wait_cnt_q         <= wait_cnt_d;
            s_ready_q          <= s_ready_d;
            core_input_ready_q <= core_input_ready_d;
            err_timeout_q      <= err_timeout_d;
        end
    end

    for (genvar g = 0; g < INPUT_SIZE; g++) begin : g_frame_out
        assign core_input_data[g*WIDTH +: WIDTH] = frame_q[g];
    end

    assign s_ready          = s_ready_q;
    assign core_input_ready = core_input_ready_q;
    assign err_timeout      = err_timeout_q;

    nn_result_serializer #(
        .WIDTH       (WIDTH),
        .OUTPUT_SIZE (OUTPUT_SIZE)
    ) u_serializer (
        .clk          (clk),
        .reset        (reset),
        .capture      (capture_s),
        .capture_data (core_output_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .done         (drain_done_s)
    );

endmodule
